// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART frame extractor.
package uart_rx_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int frame_w(
    input int data_w,
    input int parity_mode,
    input int stop_bits
  );
    return 1 + data_w + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_extractor.sv
// UART frame decoder feeding a show-ahead output FIFO.
// Define FRAME_EXTRACTOR_ERR_DROP_EN to discard frames with errors.
module frame_extractor
  import uart_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int FRAME_W = frame_w(DATA_W, PARITY_MODE, STOP_BITS),
  localparam int CW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] packet,
  input  logic               packet_valid,
  output logic [DATA_W-1:0]  data,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow,
  output logic [7:0]         drop_count,
  output logic [CW-1:0]      fifo_count
);

  localparam int EW = DATA_W + 2;

  logic [FRAME_W-1:0]   pkt_q;
  logic                 v1;
  logic [DATA_W-1:0]    dec_data;
  logic [DATA_W:0]      par_field;
  logic [STOP_BITS-1:0] stop;
  logic                 perr;
  logic                 ferr;
  logic                 err_drop;
  logic                 push_req;
  logic                 full_drop;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [EW-1:0]        head;

  assign dec_data  = pkt_q[DATA_W:1];
  assign par_field = pkt_q[DATA_W+1:1];
  assign stop      = pkt_q[FRAME_W-1 -: STOP_BITS];
  assign ferr      = pkt_q[0] | ~(&stop);

  always_comb begin
    perr = 1'b0;
    unique case (1'b1)
      (PARITY_MODE == PARITY_EVEN): perr = ^par_field;
      (PARITY_MODE == PARITY_ODD):  perr = ~(^par_field);
      default:                      perr = 1'b0;
    endcase
  end

`ifdef FRAME_EXTRACTOR_ERR_DROP_EN
  assign err_drop   = v1 & ~reset & (perr | ferr);
  assign parity_err = 1'b0;
  assign frame_err  = 1'b0;
`else
  assign err_drop   = 1'b0;
  assign parity_err = head[1];
  assign frame_err  = head[0];
`endif

  assign push_req   = v1 & ~reset & ~err_drop;
  assign pop        = data_valid & data_ready;
  assign full_drop  = push_req & full & ~pop;
  assign data_valid = ~empty;
  assign data       = head[EW-1:2];

  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata ({dec_data, perr, ferr}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1         <= 1'b0;
      pkt_q      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      v1       <= packet_valid;
      overflow <= full_drop;
      if (packet_valid) pkt_q <= packet;
      if ((full_drop | err_drop) && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule
